wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Shares the port between the in-order pipeline writeback result (ResultW path) and a late-returning auxiliary source, such as a multi-cycle mul/div unit or a deferred load return.
- Buffers aux results in a small FIFO and squashes WAW-stale entries.
- Requests a one-cycle pipeline stall when the aux head has waited too long.

Parameters:
DEPTH, 2, aux FIFO entries (power of two, >=2)
MAX_WAIT, 4, cycles the aux head may be blocked by pipe writes before a stall is forced

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, asserted HIGH (name kept for consistency; 1 = reset)
pipe_we  in  1  pipeline writeback write enable (RegWriteW)
pipe_waddr  in  5  pipeline destination register
pipe_wdata  in  32  pipeline result (ResultW)
aux_valid  in  1  aux result offered
aux_ready  out  1  aux result accepted this cycle when valid&ready
aux_waddr  in  5  aux destination register
aux_wdata  in  32  aux result
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
stall_req  out  1  pipeline must hold its WB stage this cycle
aux_pending  out  1  FIFO holds at least one valid entry (hazard unit uses it)

Behaviour:
- Reset (async, rst_n=1):
  - FIFO empty; all entry valid bits cleared; wait_cnt=0.
  - While asserted: rf_we=0, aux_ready=0, stall_req=0, aux_pending=0, rf_waddr=0, rf_wdata=0.
  - Reset mid-operation discards all buffered aux results.
- Aux FIFO:
  - aux_ready = !full. There is no accept-while-full, even in a pop cycle.
  - An accepted entry enters at the tail with valid=1. It is never written to the RF in its acceptance cycle, so minimum aux latency is 1 cycle.
- Port grant each cycle, in priority order:
  - (a) stall_req=1: aux head is written.
  - (b) pipe_we=1 and pipe_waddr!=0: pipe is written combinationally (zero latency).
  - (c) otherwise, if the head is valid: aux head is written.
  - Else rf_we=0.
- stall_req = pipe_we & head_valid & (wait_cnt==MAX_WAIT). It is combinational from registered state.
  - The pipeline holds pipe_* stable.
  - The held pipe write is granted on the next cycle.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, in any cycle a valid head is blocked by a pipe grant.
  - Clears on every head pop and whenever the FIFO is empty.
- Head pop:
  - Occurs on an aux grant.
  - Also occurs when the head is invalid (squashed); this consumes the cycle without a write, rf_we=0 for aux.
- Register $0: any write with address 0 gives rf_we=0. A pipe write to $0 does not take the port, so aux may use that cycle. An aux entry to $0 pops without writing.
- WAW squash:
  - Buffered entries are older than any concurrent pipe write.
  - On a granted pipe write, every valid FIFO entry with a matching waddr has valid cleared in the same cycle.
  - An entry accepted in the same cycle with a matching address is NOT squashed.
- Simultaneous accept and pop: occupancy is unchanged and pointers advance modulo DEPTH.
- aux_pending = OR of entry valid bits.

Decomposition:
- Shared package: REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0, and an entry struct {valid, waddr, wdata}.
- One sub-module: wb_aux_fifo. It holds DEPTH entries with per-entry squash-by-address and exposes head/full/any_valid.
- The arbiter holds grant logic and wait_cnt.

Test Plan:
- Reset asserted mid-stream with 2 buffered entries -> rf_we=0 and aux_ready=0 during reset; after release aux_pending=0 and the first cycle writes nothing.
- Idle pipe; aux offers (r5,0x11) at cycle 0 -> aux_ready=1; at cycle 1 rf_we=1, rf_waddr=5, rf_wdata=0x11; aux_pending=0 at cycle 2.
- Aux offers r7 then continuous pipe_we to r3 -> head blocked 4 cycles; at cycle 5 stall_req=1 and rf writes r7; at cycle 6 rf writes the held r3.
- Buffer (r9,0xAA); pipe writes (r9,0xBB) -> RF gets 0xBB; next idle cycle the head pops with rf_we=0 and the final r9 value is 0xBB.
- DEPTH=2 with pipe_we held 1 and aux_valid held 1 -> after 2 accepts aux_ready=0; after the stall pop, aux_ready=1 again.
- Pipe writes $0 while an aux r4 entry is at the head -> rf_we=1 with rf_waddr=4 in that cycle; no write to $0 ever occurs.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One buffered aux result; valid is cleared when a younger pipe write hits the same register.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
    } wbEntry_t;

    // Which source owns the write port in the current cycle.
    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PIPE,
        GRANT_AUX
    } grant_t;

    function automatic logic isRegZero(input logic [REG_ADDR_W-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus: pipeline result, aux result handshake, register-file port and hazard outputs.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0]     pipe_wdata;

    logic                  aux_valid;
    logic                  aux_ready;
    logic [REG_ADDR_W-1:0] aux_waddr;
    logic [DATA_W-1:0]     aux_wdata;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;

    logic                  stall_req;
    logic                  aux_pending;

    // Arbiter side.
    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  aux_valid, aux_waddr, aux_wdata,
        output aux_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_req, aux_pending
    );

    // Pipeline / aux producer side.
    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output aux_valid, aux_waddr, aux_wdata,
        input  aux_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_req, aux_pending
    );

endinterface

// File: rtl/wb_aux_fifo.sv
// Small FIFO of late aux results with per-entry squash by destination register.
module wb_aux_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] pushAddr,
    input  logic [DATA_W-1:0]     pushData,
    input  logic                  pop,
    input  logic                  squashEn,
    input  logic [REG_ADDR_W-1:0] squashAddr,
    output wbEntry_t              head,
    output logic                  full,
    output logic                  empty,
    output logic                  anyValid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wbEntry_t         entries [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_FULL);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign head   = entries[rdPtr];

    // Squash, then pop, then push: a same-cycle push lands with valid set even if its address matches.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (squashEn) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (entries[i].valid && entries[i].waddr == squashAddr) begin
                        entries[i].valid <= 1'b0;
                    end
                end
            end
            if (doPop) begin
                entries[rdPtr].valid <= 1'b0;
                rdPtr                <= rdPtr + 1'b1;
            end
            if (doPush) begin
                entries[wrPtr] <= '{valid: 1'b1, waddr: pushAddr, wdata: pushData};
                wrPtr          <= wrPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Freed slots always have valid cleared, so a plain OR over all slots tracks live entries.
    always_comb begin
        anyValid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            anyValid = anyValid | entries[i].valid;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback and buffered aux results.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_port_arbiter_if.slave   bus
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    wbEntry_t          head;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              anyValid;
    logic              headValid;
    logic [WAIT_W-1:0] waitCnt;
    logic              stallReq;
    logic              pipeTakesPort;
    logic              auxReady;
    logic              push;
    grant_t            grant;

    assign headValid     = ~fifoEmpty & head.valid;
    assign stallReq      = bus.pipe_we & headValid & (waitCnt == WAIT_LIMIT);
    assign pipeTakesPort = bus.pipe_we & ~isRegZero(bus.pipe_waddr);
    assign auxReady      = ~fifoFull & ~rst_n;
    assign push          = bus.aux_valid & auxReady;

    assign bus.aux_ready   = auxReady;
    assign bus.stall_req   = stallReq & ~rst_n;
    assign bus.aux_pending = anyValid & ~rst_n;

    // Port grant: forced aux drain, then pipe, then aux head (a squashed head still takes its slot to pop).
    always_comb begin
        grant = GRANT_NONE;
        if (rst_n) begin
            grant = GRANT_NONE;
        end else if (stallReq) begin
            grant = GRANT_AUX;
        end else if (pipeTakesPort) begin
            grant = GRANT_PIPE;
        end else if (!fifoEmpty) begin
            grant = GRANT_AUX;
        end
    end

    // Drive the register-file port from the granted source; $0 and squashed entries never write.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        case (grant)
            GRANT_PIPE: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.pipe_waddr;
                bus.rf_wdata = bus.pipe_wdata;
            end
            GRANT_AUX: begin
                if (headValid && !isRegZero(head.waddr)) begin
                    bus.rf_we    = 1'b1;
                    bus.rf_waddr = head.waddr;
                    bus.rf_wdata = head.wdata;
                end
            end
            default: ;
        endcase
    end

    // Count cycles a valid head loses the port to the pipe; saturates at the stall threshold.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            waitCnt <= '0;
        end else if (grant == GRANT_AUX || fifoEmpty) begin
            waitCnt <= '0;
        end else if (headValid && grant == GRANT_PIPE && waitCnt != WAIT_LIMIT) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    wb_aux_fifo #(
        .DEPTH (DEPTH)
    ) auxFifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pushAddr   (bus.aux_waddr),
        .pushData   (bus.aux_wdata),
        .pop        (grant == GRANT_AUX),
        .squashEn   (grant == GRANT_PIPE),
        .squashAddr (bus.pipe_waddr),
        .head       (head),
        .full       (fifoFull),
        .empty      (fifoEmpty),
        .anyValid   (anyValid)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: table of single-cycle vectors plus hand-written multi-cycle sequences.
module tb_wb_port_arbiter;

    logic clk;
    logic rst_n;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        pwe;
        logic [4:0]  paddr;
        logic [31:0] pdata;
        logic        av;
        logic [4:0]  aaddr;
        logic [31:0] adata;
        logic        eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic        eStall;
        logic        eReady;
        logic        ePend;
    } vec_t;

    vec_t        vecs[$];
    int          nChecks    = 0;
    int          nFails     = 0;
    int          zeroWrites = 0;
    logic [31:0] rfShadow [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: captures every write the DUT presents.
    always @(negedge clk) begin
        if (!rst_n && bus.rf_we) begin
            rfShadow[bus.rf_waddr] = bus.rf_wdata;
            if (bus.rf_waddr == 5'd0) zeroWrites++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mkVec(string name,
                                   logic pwe, logic [4:0] paddr, logic [31:0] pdata,
                                   logic av, logic [4:0] aaddr, logic [31:0] adata,
                                   logic eWe, logic [4:0] eAddr, logic [31:0] eData,
                                   logic eStall, logic eReady, logic ePend);
        vec_t v;
        v.name = name;
        v.pwe = pwe; v.paddr = paddr; v.pdata = pdata;
        v.av = av; v.aaddr = aaddr; v.adata = adata;
        v.eWe = eWe; v.eAddr = eAddr; v.eData = eData;
        v.eStall = eStall; v.eReady = eReady; v.ePend = ePend;
        return v;
    endfunction

    task automatic checkOut(string name, logic eWe, logic [4:0] eAddr, logic [31:0] eData,
                            logic eStall, logic eReady, logic ePend);
        logic [40:0] got;
        logic [40:0] exp;
        got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_req, bus.aux_ready, bus.aux_pending};
        exp = {eWe, eAddr, eData, eStall, eReady, ePend};
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got we=%0b addr=%0d data=%h stall=%0b ready=%0b pend=%0b, expected we=%0b addr=%0d data=%h stall=%0b ready=%0b pend=%0b",
                     name, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_req, bus.aux_ready, bus.aux_pending,
                     eWe, eAddr, eData, eStall, eReady, ePend);
        end
    endtask

    task automatic checkVal(string name, logic [31:0] got, logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Called just after a rising edge: apply inputs, check at the falling edge, advance to the next edge.
    task automatic runCycle(vec_t v);
        bus.pipe_we    = v.pwe;
        bus.pipe_waddr = v.paddr;
        bus.pipe_wdata = v.pdata;
        bus.aux_valid  = v.av;
        bus.aux_waddr  = v.aaddr;
        bus.aux_wdata  = v.adata;
        @(negedge clk);
        checkOut(v.name, v.eWe, v.eAddr, v.eData, v.eStall, v.eReady, v.ePend);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rfShadow[i] = '0;
        rst_n          = 1'b1;
        bus.pipe_we    = 1'b1;
        bus.pipe_waddr = 5'd3;
        bus.pipe_wdata = 32'h1234;
        bus.aux_valid  = 1'b1;
        bus.aux_waddr  = 5'd4;
        bus.aux_wdata  = 32'h5678;

        // Reset state with active inputs: everything held low.
        @(negedge clk);
        checkOut("reset_state", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // name, pwe paddr pdata, av aaddr adata, eWe eAddr eData eStall eReady ePend
        vecs.push_back(mkVec("idle",            0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("pipe_r1",         1, 1, 32'h100,    0, 0,  0,      1, 1,  32'h100, 0, 1, 0));
        vecs.push_back(mkVec("aux_r5_accept",   0, 0, 0,          1, 5,  32'h11, 0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("aux_r5_write",    0, 0, 0,          0, 0,  0,      1, 5,  32'h11, 0, 1, 1));
        vecs.push_back(mkVec("aux_r5_drained",  0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("pipe_r0_acc_r4",  1, 0, 32'hDEAD,   1, 4,  32'h44, 0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("pipe_r0_aux_r4",  1, 0, 32'hDEAD,   0, 0,  0,      1, 4,  32'h44, 0, 1, 1));
        vecs.push_back(mkVec("after_r4",        0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("aux_r0_accept",   0, 0, 0,          1, 0,  32'h55, 0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("aux_r0_pop",      0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 1));
        vecs.push_back(mkVec("after_r0",        0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("aux_r9_accept",   0, 0, 0,          1, 9,  32'hAA, 0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("pipe_r9_squash",  1, 9, 32'hBB,     0, 0,  0,      1, 9,  32'hBB, 0, 1, 1));
        vecs.push_back(mkVec("squashed_pop",    0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("after_squash",    0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("same_cycle_r6",   1, 6, 32'h66,     1, 6,  32'h77, 1, 6,  32'h66, 0, 1, 0));
        vecs.push_back(mkVec("aux_r6_kept",     0, 0, 0,          0, 0,  0,      1, 6,  32'h77, 0, 1, 1));
        vecs.push_back(mkVec("after_r6",        0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("aux_r10_accept",  0, 0, 0,          1, 10, 32'hA0, 0, 0,  0,      0, 1, 0));
        vecs.push_back(mkVec("acc_r11_pop_r10", 0, 0, 0,          1, 11, 32'hB0, 1, 10, 32'hA0, 0, 1, 1));
        vecs.push_back(mkVec("aux_r11_write",   0, 0, 0,          0, 0,  0,      1, 11, 32'hB0, 0, 1, 1));
        vecs.push_back(mkVec("after_r11",       0, 0, 0,          0, 0,  0,      0, 0,  0,      0, 1, 0));

        foreach (vecs[i]) runCycle(vecs[i]);

        checkVal("final_r9", rfShadow[9], 32'hBB);
        checkVal("final_r6", rfShadow[6], 32'h77);

        // Head r7 blocked by a continuous pipe write to r3 until the stall drains it.
        runCycle(mkVec("A.accept_r7", 0, 0, 0, 1, 7, 32'h70, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 4; k++) begin
            runCycle(mkVec($sformatf("A.blocked%0d", k), 1, 3, 32'h33, 0, 0, 0, 1, 3, 32'h33, 0, 1, 1));
        end
        runCycle(mkVec("A.stall_r7", 1, 3, 32'h33, 0, 0, 0, 1, 7, 32'h70, 1, 1, 1));
        runCycle(mkVec("A.held_r3",  1, 3, 32'h33, 0, 0, 0, 1, 3, 32'h33, 0, 1, 0));
        runCycle(mkVec("A.idle",     0, 0, 0,      0, 0, 0, 0, 0, 0,      0, 1, 0));

        // FIFO fills under continuous pipe and aux traffic; the stall pop frees a slot.
        for (int k = 0; k <= 6; k++) begin
            logic        eWe;
            logic [4:0]  eAddr;
            logic [31:0] eData;
            logic        eStall;
            logic        eReady;
            logic        ePend;
            eWe    = 1'b1;
            eAddr  = (k == 5) ? 5'd12 : 5'd2;
            eData  = (k == 5) ? 32'hC0 : 32'h22;
            eStall = (k == 5);
            eReady = (k <= 1) || (k == 6);
            ePend  = (k != 0);
            runCycle(mkVec($sformatf("B.cycle%0d", k), 1, 2, 32'h22, 1, 12, 32'hC0 + k,
                           eWe, eAddr, eData, eStall, eReady, ePend));
        end
        runCycle(mkVec("B.drain_c1", 0, 0, 0, 0, 0, 0, 1, 12, 32'hC1, 0, 0, 1));
        runCycle(mkVec("B.drain_c6", 0, 0, 0, 0, 0, 0, 1, 12, 32'hC6, 0, 1, 1));
        runCycle(mkVec("B.empty",    0, 0, 0, 0, 0, 0, 0, 0,  0,      0, 1, 0));

        // Reset mid-stream with two buffered entries discards them.
        runCycle(mkVec("C.fill0", 1, 2, 32'h22, 1, 13, 32'hD0, 1, 2, 32'h22, 0, 1, 0));
        runCycle(mkVec("C.fill1", 1, 2, 32'h22, 1, 14, 32'hD1, 1, 2, 32'h22, 0, 1, 1));
        rst_n = 1'b1;
        runCycle(mkVec("C.reset0", 1, 2, 32'h22, 1, 15, 32'hD2, 0, 0, 0, 0, 0, 0));
        runCycle(mkVec("C.reset1", 1, 2, 32'h22, 1, 15, 32'hD2, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        runCycle(mkVec("C.post0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        runCycle(mkVec("C.post1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        checkVal("no_r0_writes", 32'(zeroWrites), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
